// File: rtl/cdc_handshake_tx.sv
// Source-domain half of a 4-phase req/ack CDC handshake with an M-flop ack synchronizer.
// Optional sticky ack-timeout flag is built only when CDC_TIMEOUT_EN is defined.
module cdc_handshake_tx #(
    parameter int DATA_WIDTH     = 8,
    parameter int M              = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  req_out,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic                  ack_in,
    output logic                  busy,
    output logic                  timeout_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ_HI = 2'd1,
        ACK_LO = 2'd2
    } state_t;

    state_t         state;
    logic [M-1:0]   ack_sync;
    logic           ack_s;
    logic           accept;

    // ack_in is asynchronous; everything downstream sees only the last flop of the chain
    always_ff @(posedge clk) begin
        if (reset) begin
            ack_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[M-2:0], ack_in};
        end
    end

    assign ack_s    = ack_sync[M-1];
    assign in_ready = (state == IDLE) && !ack_s;
    assign accept   = in_valid && in_ready;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            req_out  <= 1'b0;
            data_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        data_out <= in_data;
                        req_out  <= 1'b1;
                        state    <= REQ_HI;
                    end
                end
                REQ_HI: begin
                    if (ack_s) begin
                        req_out <= 1'b0;
                        state   <= ACK_LO;
                    end
                end
                ACK_LO: begin
                    if (!ack_s) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    req_out <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

`ifdef CDC_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] to_cnt;

    // The flag only reports a slow ack; the handshake itself keeps waiting
    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt      <= '0;
            timeout_err <= 1'b0;
        end else if (accept) begin
            to_cnt <= '0;
        end else if ((state == REQ_HI) && !ack_s && (to_cnt != TO_LIMIT)) begin
            to_cnt <= to_cnt + CW'(1);
            if (to_cnt == (TO_LIMIT - CW'(1))) begin
                timeout_err <= 1'b1;
            end
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

    a_data_stable : assert property (@(posedge clk) disable iff (reset)
        (req_out && $past(req_out)) |-> $stable(data_out));

    a_no_req_on_ack : assert property (@(posedge clk) disable iff (reset)
        $rose(req_out) |-> !$past(ack_s));

    a_state_legal : assert property (@(posedge clk) disable iff (reset)
        state inside {IDLE, REQ_HI, ACK_LO});

    a_param_legal : assert property (@(posedge clk) disable iff (reset)
        (M >= 2) && (TIMEOUT_CYCLES >= 1));

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Directed bench for cdc_handshake_tx (M=2): vector table plus hand-written corner sequences.
module tb_cdc_handshake_tx;

    localparam int DW = 8;
    localparam int M  = 2;
    localparam int TC = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          req_out;
    logic [DW-1:0] data_out;
    logic          ack_in;
    logic          busy;
    logic          timeout_err;

    logic          ack_drive;
    logic          resp_en;
    logic [3:0]    resp_hist;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic          rst;
        logic          valid;
        logic [DW-1:0] data;
        logic          ack;
        logic          exp_ready;
        logic          exp_req;
        logic [DW-1:0] exp_data;
        logic          exp_busy;
    } vec_t;

    vec_t vecs[21];

    cdc_handshake_tx #(
        .DATA_WIDTH(DW),
        .M(M),
        .TIMEOUT_CYCLES(TC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .req_out(req_out),
        .data_out(data_out),
        .ack_in(ack_in),
        .busy(busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Remote responder: ack follows req with a fixed 4-cycle delay when enabled
    always @(posedge clk) begin
        if (!resp_en) resp_hist <= '0;
        else          resp_hist <= {resp_hist[2:0], req_out};
    end

    assign ack_in = resp_en ? resp_hist[3] : ack_drive;

    task automatic applyStimulus(input logic r, input logic v, input logic [DW-1:0] d, input logic a);
        reset     = r;
        in_valid  = v;
        in_data   = d;
        ack_drive = a;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic       prev_req;
    logic [7:0] prev_data;
    logic [7:0] capt[4];
    int         rise_cyc[4];
    int         rises, accepted, stable_viol, ready_viol;
    logic       acc;

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        ack_drive = 1'b0;
        resp_en   = 1'b0;

        //          rst valid data   ack  rdy req data   busy
        vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0};
        vecs[17] = '{1'b0, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0};
        vecs[18] = '{1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0};
        vecs[19] = '{1'b0, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0};
        vecs[20] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0};

        // Reset, single transfer with delayed ack, spurious ack while idle
        for (int i = 0; i < 21; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].valid, vecs[i].data, vecs[i].ack);
            checkOutput($sformatf("v%0d_ready", i), 8'(in_ready), 8'(vecs[i].exp_ready));
            checkOutput($sformatf("v%0d_req", i),   8'(req_out),  8'(vecs[i].exp_req));
            checkOutput($sformatf("v%0d_data", i),  data_out,     vecs[i].exp_data);
            checkOutput($sformatf("v%0d_busy", i),  8'(busy),     8'(vecs[i].exp_busy));
            checkOutput($sformatf("v%0d_terr", i),  8'(timeout_err), 8'h00);
        end

        // Back-to-back words against the 4-cycle responder
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        reset       = 1'b0;
        resp_en     = 1'b1;
        in_valid    = 1'b1;
        in_data     = 8'h11;
        rises       = 0;
        accepted    = 0;
        stable_viol = 0;
        ready_viol  = 0;
        prev_req    = req_out;
        prev_data   = data_out;
        for (int c = 0; c < 40; c++) begin
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (busy && in_ready) ready_viol++;
            if (req_out && prev_req && (data_out !== prev_data)) stable_viol++;
            if (req_out && !prev_req) begin
                if (rises < 4) begin
                    capt[rises]     = data_out;
                    rise_cyc[rises] = c;
                end
                rises++;
            end
            if (acc) begin
                accepted++;
                if (accepted == 1) in_data = 8'h22;
                else               in_valid = 1'b0;
            end
            prev_req  = req_out;
            prev_data = data_out;
        end
        checkOutput("b2b_rises", 8'(rises), 8'd2);
        checkOutput("b2b_word0", capt[0], 8'h11);
        checkOutput("b2b_word1", capt[1], 8'h22);
        checkOutput("b2b_period", 8'(rise_cyc[1] - rise_cyc[0]), 8'd15);
        checkOutput("b2b_stable", 8'(stable_viol), 8'd0);
        checkOutput("b2b_ready_busy", 8'(ready_viol), 8'd0);
        checkOutput("b2b_idle_end", 8'(busy), 8'd0);
        resp_en = 1'b0;

        // Stuck remote ack across reset
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < M; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("stuck_ready", 8'(in_ready), 8'd0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b1, 8'h99, 1'b1);
            checkOutput($sformatf("stuck_req%0d", i), 8'(req_out), 8'd0);
        end
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("release_ready_early", 8'(in_ready), 8'd0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("release_ready", 8'(in_ready), 8'd1);
        checkOutput("release_data", data_out, 8'h00);

        // Reset in the middle of REQ_HI
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h3C, 1'b0);
        checkOutput("mid_req_hi", 8'(req_out), 8'd1);
        checkOutput("mid_data_hi", data_out, 8'h3C);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        checkOutput("mid_req_rst", 8'(req_out), 8'd0);
        checkOutput("mid_data_rst", data_out, 8'h00);
        checkOutput("mid_busy_rst", 8'(busy), 8'd0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("mid_ready_after", 8'(in_ready), 8'd1);

`ifdef CDC_TIMEOUT_EN
        // Ack never arrives: flag after TC REQ_HI cycles, handshake still completes
        applyStimulus(1'b0, 1'b1, 8'hC3, 1'b0);
        for (int i = 0; i < TC - 1; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("to_err_early", 8'(timeout_err), 8'd0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("to_err_set", 8'(timeout_err), 8'd1);
        checkOutput("to_req_held", 8'(req_out), 8'd1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("to_req_drop", 8'(req_out), 8'd0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("to_idle", 8'(busy), 8'd0);
        checkOutput("to_err_sticky", 8'(timeout_err), 8'd1);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        checkOutput("to_err_reset", 8'(timeout_err), 8'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cdc_handshake_tx.md
Name: cdc_handshake_tx

Overview:
- Source-domain half of a 4-phase req/ack clock-domain-crossing handshake.
- Accepts a word from local logic over valid/ready and holds it stable on data_out for the whole transfer.
- Raises req_out toward the destination domain, whose mux-style synchronizer captures data_out once its synchronized req is seen.
- Synchronizes the returning ack through an M-flop chain and sequences the handshake back to idle.

Parameters:
- DATA_WIDTH, 8: width of the transferred word.
- M, 2: flops in the ack synchronizer chain; legal range is 2 and above.
- TIMEOUT_CYCLES, 1024: used only with CDC_TIMEOUT_EN; the ack wait limit in clk cycles.

Ports:
- clk  in  1  source-domain clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  local word available.
- in_ready  out  1  block can accept a word this cycle.
- in_data  in  DATA_WIDTH  local word.
- req_out  out  1  registered request to the destination domain.
- data_out  out  DATA_WIDTH  registered word sent to the destination domain.
- ack_in  in  1  asynchronous ack from the destination domain.
- busy  out  1  high whenever state is not IDLE.
- timeout_err  out  1  sticky ack-timeout flag; tied 0 without CDC_TIMEOUT_EN.

Behaviour:
- Reset: all of the following are synchronous and active-high on posedge clk.
  - state=IDLE, req_out=0, data_out=0, busy=0, timeout_err=0.
  - ack synchronizer flops all cleared to 0.
- Ack synchronizer:
  - ack_s is the last flop of the M-flop chain on ack_in.
  - An ack_in edge is visible on ack_s M cycles later.
  - No logic may use ack_in directly; only ack_s is used.
- in_ready is combinational: in_ready = (state==IDLE) && !ack_s.
- Accept occurs when in_valid && in_ready at edge t. At t+1:
  - data_out=in_data.
  - req_out=1.
  - state=REQ_HI.
- REQ_HI: hold req_out=1 and data_out. When ack_s==1, at the next edge:
  - req_out=0.
  - state=ACK_LO.
- ACK_LO: hold data_out. When ack_s==0, at the next edge state=IDLE.
- data_out changes only on an accept. It is otherwise frozen, including while idle.
- Minimum source-cycle cost per word is 2*M+3 cycles, plus the destination-side delay.
- busy = (state!=IDLE), driven from the registered state.
- in_valid while not ready: ignored. No queuing is done; the upstream keeps in_data/in_valid until accepted.
- ack_s rising in IDLE (spurious, or a leftover from a prior reset) causes:
  - in_ready=0.
  - no request.
  - the block stays IDLE until ack_s returns to 0.
- ack_s falling in REQ_HI: no effect, keep waiting.
- Reset mid-transfer:
  - req_out drops immediately at the reset edge.
  - After reset, any still-high remote ack blocks acceptance (via ack_s) until it is released, so no handshake overlap is possible.
- Assertions, disabled during reset:
  - data_out is $stable while req_out is high.
  - req_out never rises while ack_s is high.
  - state is always one of IDLE/REQ_HI/ACK_LO.

Optional Feature:
- Macro: CDC_TIMEOUT_EN.
- When defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entering REQ_HI.
  - It increments each REQ_HI cycle with ack_s==0 and saturates.
  - On reaching TIMEOUT_CYCLES, timeout_err is set to 1. It is sticky until reset.
  - The handshake is unaffected: req_out stays high and the block keeps waiting.
- When undefined: no counter logic, and timeout_err is constant 0.

Test Plan:
- Reset then idle, with M=2:
  - Expected: in_ready=1, req_out=0, data_out=0x00, busy=0.
- Single transfer: in_valid=1 with in_data=0xA5 at cycle 0; ack_in is raised 3 cycles after req_out rises and dropped 3 cycles after req_out falls.
  - req_out=1 and data_out=0xA5 at cycle 1.
  - req_out falls 3 cycles after ack_in rises (M=2 sync plus 1 register).
  - in_ready returns 3 cycles after ack_in falls.
  - data_out stays 0xA5 throughout.
- Back-to-back: in_valid held high with 0x11 then 0x22; an ack responder with a fixed 4-cycle delay.
  - Each word is sent exactly once, in order.
  - 0x22 is not accepted while busy.
  - data_out never changes while req_out=1.
- Stuck ack: ack_in=1 forced, then reset.
  - After reset, in_ready=0 and req_out stays 0.
  - Release ack_in: in_ready=1 M cycles later.
- Reset mid-transfer: assert reset during REQ_HI with data 0x3C.
  - Next cycle: req_out=0, data_out=0x00, state IDLE.
- Timeout with CDC_TIMEOUT_EN and TIMEOUT_CYCLES=16: accept a word and never ack.
  - timeout_err=1 after 16 REQ_HI cycles; req_out remains 1.
  - A later ack completes the handshake normally, and timeout_err stays 1 until reset.
